// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for a debounced lock, then releases core reset.
// Retries on lock timeout, latches failure, and restarts the PLL whenever lock drops in RUN.
module pll_reset_ctrl #(
  parameter int unsigned RST_PULSE_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 5000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 7,
  parameter int unsigned RETRY_W             = 3
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               soft_reset,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_reset,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               fail,
  output logic               lock_lost
);

  localparam int unsigned MaxAb     = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                      RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned MaxCycles = (MaxAb > STABLE_CYCLES) ? MaxAb : STABLE_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  localparam logic [CntW-1:0]    PulseLast   = CntW'(RST_PULSE_CYCLES - 1);
  localparam logic [CntW-1:0]    TimeoutLast = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0]    StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RetryMax    = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPllRst,
    StWaitLock,
    StStable,
    StRun,
    StFail
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               lock_lost_q, lock_lost_d;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_reset_q, sys_reset_d;
  logic               fail_q, fail_d;
  logic [1:0]         lk_sync_q;
  logic               lk_s;

  // pll_locked comes from the PLL clock domain; only lk_s is used downstream.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lk_sync_q <= 2'b00;
    end else begin
      lk_sync_q <= {lk_sync_q[0], pll_locked};
    end
  end

  assign lk_s = lk_sync_q[1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q     <= StPllRst;
      cnt_q       <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_reset_q <= 1'b1;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      lock_lost_q <= lock_lost_d;
      pll_rst_q   <= pll_rst_d;
      sys_reset_q <= sys_reset_d;
      fail_q      <= fail_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CntW'(1);
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    if (soft_reset) begin
      state_d     = StPllRst;
      cnt_d       = '0;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      unique case (state_q)
        StPllRst: begin
          if (cnt_q == PulseLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end
        end
        StWaitLock: begin
          // Lock is checked first so a lock arriving on the timeout cycle wins.
          if (lk_s) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == TimeoutLast) begin
            cnt_d = '0;
            if (retry_q == RetryMax) begin
              state_d = StFail;
            end else begin
              state_d = StPllRst;
              retry_d = retry_q + RETRY_W'(1);
            end
          end
        end
        StStable: begin
          if (!lk_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else if (cnt_q == StableLast) begin
            state_d = StRun;
            cnt_d   = '0;
            retry_d = '0;
          end
        end
        StRun: begin
          cnt_d = '0;
          if (!lk_s) begin
            state_d     = StPllRst;
            lock_lost_d = 1'b1;
          end
        end
        StFail: begin
          cnt_d = '0;
        end
        default: begin
          state_d = StPllRst;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state register.
  always_comb begin
    pll_rst_d   = (state_d == StPllRst);
    sys_reset_d = (state_d != StRun);
    fail_d      = (state_d == StFail);
  end

  assign pll_rst   = pll_rst_q;
  assign sys_reset = sys_reset_q;
  assign retry_cnt = retry_q;
  assign fail      = fail_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with short parameters; edge numbers in comments count
// rising edges after the most recent reset release.
module tb_pll_reset_ctrl;

  localparam int unsigned RetryW = 2;

  logic              refclk = 1'b0;
  logic              rst = 1'b1;
  logic              soft_reset = 1'b0;
  logic              pll_locked = 1'b0;
  logic              pll_rst;
  logic              sys_reset;
  logic [RetryW-1:0] retry_cnt;
  logic              fail;
  logic              lock_lost;

  int checks = 0;
  int passed = 0;

  pll_reset_ctrl #(
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .STABLE_CYCLES      (8),
    .MAX_RETRIES        (2),
    .RETRY_W            (RetryW)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .soft_reset(soft_reset),
    .pll_locked(pll_locked),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .retry_cnt (retry_cnt),
    .fail      (fail),
    .lock_lost (lock_lost)
  );

  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Leaves the bench 1 ns after edge 0 with rst just released.
  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    logic seen;

    // Reset state
    step(2);
    check("rst pll_rst", 32'(pll_rst), 1);
    check("rst sys_reset", 32'(sys_reset), 1);
    check("rst retry_cnt", 32'(retry_cnt), 0);
    check("rst fail", 32'(fail), 0);
    check("rst lock_lost", 32'(lock_lost), 0);

    // Nominal lock: pll_locked rises after edge 10, sys_reset falls at edge 21
    rst = 1'b0;
    step(3);
    check("nom pll_rst e3", 32'(pll_rst), 1);
    step(1);
    check("nom pll_rst e4", 32'(pll_rst), 0);
    check("nom sys_reset e4", 32'(sys_reset), 1);
    step(6);
    pll_locked = 1'b1;
    step(10);
    check("nom sys_reset e20", 32'(sys_reset), 1);
    step(1);
    check("nom sys_reset e21", 32'(sys_reset), 0);
    check("nom retry_cnt", 32'(retry_cnt), 0);
    check("nom fail", 32'(fail), 0);

    // Glitch in STABLE: one-cycle drop of pll_locked; restart of the stable count, no PLL pulse
    pll_locked = 1'b0;
    do_reset();
    step(4);
    pll_locked = 1'b1;
    step(6);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    check("glitch sys_reset e12", 32'(sys_reset), 1);
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      step(1);
      seen = seen | pll_rst;
    end
    check("glitch no pll_rst pulse", 32'(seen), 0);
    check("glitch sys_reset e21", 32'(sys_reset), 1);
    step(1);
    check("glitch sys_reset e22", 32'(sys_reset), 0);
    check("glitch retry_cnt", 32'(retry_cnt), 0);

    // Never locks: three pulses, then FAIL
    pll_locked = 1'b0;
    do_reset();
    step(23);
    check("nolock pll_rst e23", 32'(pll_rst), 0);
    check("nolock retry e23", 32'(retry_cnt), 0);
    step(1);
    check("nolock pll_rst e24", 32'(pll_rst), 1);
    check("nolock retry e24", 32'(retry_cnt), 1);
    step(3);
    check("nolock pll_rst e27", 32'(pll_rst), 1);
    step(1);
    check("nolock pll_rst e28", 32'(pll_rst), 0);
    step(19);
    check("nolock pll_rst e47", 32'(pll_rst), 0);
    step(1);
    check("nolock pll_rst e48", 32'(pll_rst), 1);
    check("nolock retry e48", 32'(retry_cnt), 2);
    step(4);
    check("nolock pll_rst e52", 32'(pll_rst), 0);
    step(19);
    check("nolock fail e71", 32'(fail), 0);
    step(1);
    check("nolock fail e72", 32'(fail), 1);
    check("nolock pll_rst e72", 32'(pll_rst), 0);
    check("nolock sys_reset e72", 32'(sys_reset), 1);
    check("nolock retry e72", 32'(retry_cnt), 2);
    step(50);
    check("nolock fail held", 32'(fail), 1);
    check("nolock pll_rst held", 32'(pll_rst), 0);
    check("nolock sys_reset held", 32'(sys_reset), 1);

    // soft_reset in FAIL (edge S), then lock and reach RUN at S+15
    soft_reset = 1'b1;
    step(1);
    soft_reset = 1'b0;
    check("softfail pll_rst", 32'(pll_rst), 1);
    check("softfail fail", 32'(fail), 0);
    check("softfail retry", 32'(retry_cnt), 0);
    check("softfail sys_reset", 32'(sys_reset), 1);
    step(3);
    check("softfail pll_rst S+3", 32'(pll_rst), 1);
    step(1);
    check("softfail pll_rst S+4", 32'(pll_rst), 0);
    pll_locked = 1'b1;
    step(10);
    check("softfail sys_reset S+14", 32'(sys_reset), 1);
    step(1);
    check("softfail sys_reset S+15", 32'(sys_reset), 0);
    check("softfail lock_lost", 32'(lock_lost), 0);

    // Lock loss in RUN: drop after edge D, restore after D+30 (one timeout retry in between)
    step(2);
    pll_locked = 1'b0;
    step(2);
    check("loss sys_reset D+2", 32'(sys_reset), 0);
    check("loss lock_lost D+2", 32'(lock_lost), 0);
    step(1);
    check("loss sys_reset D+3", 32'(sys_reset), 1);
    check("loss lock_lost D+3", 32'(lock_lost), 1);
    check("loss pll_rst D+3", 32'(pll_rst), 1);
    step(3);
    check("loss pll_rst D+6", 32'(pll_rst), 1);
    step(1);
    check("loss pll_rst D+7", 32'(pll_rst), 0);
    step(20);
    check("loss pll_rst D+27", 32'(pll_rst), 1);
    check("loss retry D+27", 32'(retry_cnt), 1);
    step(3);
    pll_locked = 1'b1;
    step(1);
    check("loss pll_rst D+31", 32'(pll_rst), 0);
    step(9);
    check("loss sys_reset D+40", 32'(sys_reset), 1);
    step(1);
    check("loss sys_reset D+41", 32'(sys_reset), 0);
    check("loss lock_lost sticky", 32'(lock_lost), 1);
    check("loss retry cleared", 32'(retry_cnt), 0);

    // soft_reset in RUN on the cycle lk_s drops (edge E+3)
    step(2);
    pll_locked = 1'b0;
    step(2);
    check("softrun lock_lost E+2", 32'(lock_lost), 1);
    check("softrun sys_reset E+2", 32'(sys_reset), 0);
    soft_reset = 1'b1;
    step(1);
    soft_reset = 1'b0;
    check("softrun pll_rst E+3", 32'(pll_rst), 1);
    check("softrun lock_lost E+3", 32'(lock_lost), 0);
    check("softrun fail E+3", 32'(fail), 0);
    check("softrun retry E+3", 32'(retry_cnt), 0);
    check("softrun sys_reset E+3", 32'(sys_reset), 1);
    step(3);
    check("softrun pll_rst E+6", 32'(pll_rst), 1);
    step(1);
    check("softrun pll_rst E+7", 32'(pll_rst), 0);
    pll_locked = 1'b1;
    step(5);
    check("stable pll_rst E+12", 32'(pll_rst), 0);
    check("stable sys_reset E+12", 32'(sys_reset), 1);

    // Async reset mid-STABLE: outputs respond without a clock edge
    #2;
    rst = 1'b1;
    pll_locked = 1'b0;
    #1;
    check("async pll_rst", 32'(pll_rst), 1);
    check("async sys_reset", 32'(sys_reset), 1);
    check("async retry", 32'(retry_cnt), 0);
    check("async fail", 32'(fail), 0);
    check("async lock_lost", 32'(lock_lost), 0);
    #2;
    rst = 1'b0;

    // Restart; lk_s first high on the exact timeout edge (24), lock wins
    step(3);
    check("restart pll_rst e3", 32'(pll_rst), 1);
    step(1);
    check("restart pll_rst e4", 32'(pll_rst), 0);
    step(17);
    pll_locked = 1'b1;
    step(3);
    check("edge-lock pll_rst e24", 32'(pll_rst), 0);
    check("edge-lock retry e24", 32'(retry_cnt), 0);
    step(7);
    check("edge-lock sys_reset e31", 32'(sys_reset), 1);
    step(1);
    check("edge-lock sys_reset e32", 32'(sys_reset), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
